mem_bus_unit: RTL and testbench

//  Parametrised memory-bus unit between the CPU controller/datapath and the instruction ROM / data RAM.

---
 rtl/mem_bus_unit_if.sv | 45 ++++
 rtl/mem_bus_unit.sv | 130 +++++++++++++
 tb/tb_mem_bus_unit.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_unit_if.sv
// Bus bundle between the core, the memory-bus unit and the ROM/RAM.
// Handshake: the core raises fetch_req or ls_req with its address/data and holds
// them until the matching one-cycle fetch_valid/ls_valid pulse; the unit ignores
// any change on the request side after it has accepted the request. Memories
// are synchronous-read: data appears the cycle after rom_en/ram_re.
interface mem_bus_unit_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 6
) ();
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic [DATA_W-1:0] fetch_data;
    logic              fetch_valid;
    logic              ls_req;
    logic              ls_we;
    logic [ADDR_W-1:0] ls_addr;
    logic [DATA_W-1:0] ls_wdata;
    logic [DATA_W-1:0] ls_rdata;
    logic              ls_valid;
    logic              stall;
    logic              rom_en;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic              ram_re;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    // The memory-bus unit itself.
    modport slave (
        input  fetch_req, fetch_addr, ls_req, ls_we, ls_addr, ls_wdata,
               rom_data, ram_rdata,
        output fetch_data, fetch_valid, ls_rdata, ls_valid, stall,
               rom_en, rom_addr, ram_re, ram_we, ram_addr, ram_wdata
    );

    // Core plus memories, seen from outside the unit.
    modport master (
        output fetch_req, fetch_addr, ls_req, ls_we, ls_addr, ls_wdata,
               rom_data, ram_rdata,
        input  fetch_data, fetch_valid, ls_rdata, ls_valid, stall,
               rom_en, rom_addr, ram_re, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/mem_bus_unit.sv
// Memory-bus unit: serialises instruction fetches and load/stores onto a
// synchronous-read ROM and RAM with configurable wait states, and stalls the
// core while an access is in flight. Loads win over fetches in IDLE.
module mem_bus_unit #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 6,
    parameter int ROM_WAIT = 0,
    parameter int RAM_WAIT = 1
) (
    input  logic          clk,
    input  logic          reset,
    mem_bus_unit_if.slave bus,
    output logic [1:0]    dbg_state
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [3:0] ROM_CNT = 4'(ROM_WAIT);
    localparam logic [3:0] RAM_CNT = 4'(RAM_WAIT);

    state_t            state;
    logic [3:0]        wait_cnt;
    logic              chan_ram;     // 1 = RAM access, 0 = ROM fetch
    logic              we_q;         // accepted access is a store
    logic [ADDR_W-1:0] rom_addr_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [DATA_W-1:0] ram_wdata_q;
    logic              rom_en_q;
    logic              ram_re_q;
    logic              ram_we_q;
    logic              fetch_valid_q;
    logic              ls_valid_q;
    logic [DATA_W-1:0] fetch_hold;
    logic [DATA_W-1:0] ls_hold;

    // Request acceptance, wait-state counting and response sequencing.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            wait_cnt      <= '0;
            chan_ram      <= 1'b0;
            we_q          <= 1'b0;
            rom_addr_q    <= '0;
            ram_addr_q    <= '0;
            ram_wdata_q   <= '0;
            rom_en_q      <= 1'b0;
            ram_re_q      <= 1'b0;
            ram_we_q      <= 1'b0;
            fetch_valid_q <= 1'b0;
            ls_valid_q    <= 1'b0;
            fetch_hold    <= '0;
            ls_hold       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.ls_req) begin
                        chan_ram   <= 1'b1;
                        we_q       <= bus.ls_we;
                        ram_addr_q <= bus.ls_addr;
                        if (bus.ls_we) begin
                            ram_wdata_q <= bus.ls_wdata;
                        end
                        ram_we_q   <= bus.ls_we;
                        ram_re_q   <= ~bus.ls_we;
                        wait_cnt   <= RAM_CNT;
                        state      <= ACCESS;
                    end else if (bus.fetch_req) begin
                        chan_ram   <= 1'b0;
                        we_q       <= 1'b0;
                        rom_addr_q <= bus.fetch_addr;
                        rom_en_q   <= 1'b1;
                        wait_cnt   <= ROM_CNT;
                        state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    // A store writes only in its first ACCESS cycle.
                    ram_we_q <= 1'b0;
                    if (wait_cnt == 4'd0) begin
                        rom_en_q      <= 1'b0;
                        ram_re_q      <= 1'b0;
                        fetch_valid_q <= ~chan_ram;
                        ls_valid_q    <= chan_ram;
                        state         <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                RESP: begin
                    // Memory data from the last enabled cycle is on the bus now;
                    // keep it so the data outputs hold after the valid pulse.
                    if (chan_ram && !we_q) begin
                        ls_hold <= bus.ram_rdata;
                    end
                    if (!chan_ram) begin
                        fetch_hold <= bus.rom_data;
                    end
                    fetch_valid_q <= 1'b0;
                    ls_valid_q    <= 1'b0;
                    state         <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.rom_en      = rom_en_q;
    assign bus.rom_addr    = rom_addr_q;
    assign bus.ram_re      = ram_re_q;
    assign bus.ram_we      = ram_we_q;
    assign bus.ram_addr    = ram_addr_q;
    assign bus.ram_wdata   = ram_wdata_q;
    assign bus.fetch_valid = fetch_valid_q;
    assign bus.ls_valid    = ls_valid_q;

    // The read result is only on the memory bus during RESP, so it is
    // forwarded there and served from the hold register afterwards.
    assign bus.fetch_data = (state == RESP && !chan_ram) ? bus.rom_data : fetch_hold;
    assign bus.ls_rdata   = (state == RESP && chan_ram && !we_q) ? bus.ram_rdata : ls_hold;

    assign bus.stall = (state == ACCESS) ||
                       (state == IDLE && (bus.fetch_req || bus.ls_req));

    assign dbg_state = state;
endmodule

// File: tb/tb_mem_bus_unit.sv
// Bench for mem_bus_unit: two 16-bit instances with different wait states and
// one 32-bit/10-bit instance, each with its own ROM/RAM model.
module tb_mem_bus_unit;
    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    logic mem_clr;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    mem_bus_unit_if #(.DATA_W(16), .ADDR_W(6))  bus0 ();
    mem_bus_unit_if #(.DATA_W(16), .ADDR_W(6))  bus1 ();
    mem_bus_unit_if #(.DATA_W(32), .ADDR_W(10)) bus2 ();
    logic [1:0] st0, st1, st2;

    mem_bus_unit #(.DATA_W(16), .ADDR_W(6), .ROM_WAIT(0), .RAM_WAIT(2))
        u0 (.clk(clk), .reset(reset), .bus(bus0), .dbg_state(st0));
    mem_bus_unit #(.DATA_W(16), .ADDR_W(6), .ROM_WAIT(2), .RAM_WAIT(3))
        u1 (.clk(clk), .reset(reset), .bus(bus1), .dbg_state(st1));
    mem_bus_unit #(.DATA_W(32), .ADDR_W(10), .ROM_WAIT(1), .RAM_WAIT(0))
        u2 (.clk(clk), .reset(reset), .bus(bus2), .dbg_state(st2));

    int rom_w [2] = '{0, 2};
    int ram_w [2] = '{2, 3};

    // ---------------- drive / observe arrays for u0/u1 ----------------
    logic        f_req [2];
    logic        l_req [2];
    logic        l_we  [2];
    logic [5:0]  f_addr [2];
    logic [5:0]  l_addr [2];
    logic [15:0] l_wdata [2];
    logic        o_fv [2], o_lv [2], o_stall [2], o_rom_en [2], o_ram_re [2], o_ram_we [2];
    logic [15:0] o_fd [2], o_ld [2], o_wdata [2];
    logic [5:0]  o_rom_addr [2], o_ram_addr [2];

    assign bus0.fetch_req = f_req[0];   assign bus1.fetch_req = f_req[1];
    assign bus0.fetch_addr = f_addr[0]; assign bus1.fetch_addr = f_addr[1];
    assign bus0.ls_req = l_req[0];      assign bus1.ls_req = l_req[1];
    assign bus0.ls_we = l_we[0];        assign bus1.ls_we = l_we[1];
    assign bus0.ls_addr = l_addr[0];    assign bus1.ls_addr = l_addr[1];
    assign bus0.ls_wdata = l_wdata[0];  assign bus1.ls_wdata = l_wdata[1];

    assign o_fv[0] = bus0.fetch_valid;  assign o_fv[1] = bus1.fetch_valid;
    assign o_lv[0] = bus0.ls_valid;     assign o_lv[1] = bus1.ls_valid;
    assign o_stall[0] = bus0.stall;     assign o_stall[1] = bus1.stall;
    assign o_rom_en[0] = bus0.rom_en;   assign o_rom_en[1] = bus1.rom_en;
    assign o_ram_re[0] = bus0.ram_re;   assign o_ram_re[1] = bus1.ram_re;
    assign o_ram_we[0] = bus0.ram_we;   assign o_ram_we[1] = bus1.ram_we;
    assign o_fd[0] = bus0.fetch_data;   assign o_fd[1] = bus1.fetch_data;
    assign o_ld[0] = bus0.ls_rdata;     assign o_ld[1] = bus1.ls_rdata;
    assign o_wdata[0] = bus0.ram_wdata; assign o_wdata[1] = bus1.ram_wdata;
    assign o_rom_addr[0] = bus0.rom_addr; assign o_rom_addr[1] = bus1.rom_addr;
    assign o_ram_addr[0] = bus0.ram_addr; assign o_ram_addr[1] = bus1.ram_addr;

    logic        f_req2;
    logic [9:0]  f_addr2;
    assign bus2.fetch_req  = f_req2;
    assign bus2.fetch_addr = f_addr2;
    assign bus2.ls_req     = 1'b0;
    assign bus2.ls_we      = 1'b0;
    assign bus2.ls_addr    = '0;
    assign bus2.ls_wdata   = '0;
    assign bus2.ram_rdata  = '0;

    // ---------------- memories ----------------
    function automatic logic [15:0] rom_val(input logic [5:0] a);
        if (a == 6'h05) return 16'hA5C3;
        return 16'h8000 | (16'(a) * 16'd257);
    endfunction

    logic [15:0] rom0 [64], rom1 [64], ram0 [64], ram1 [64];
    logic [31:0] rom2 [1024];
    logic [15:0] rom_q0, rom_q1, ram_q0, ram_q1;
    logic [31:0] rom_q2;
    assign bus0.rom_data = rom_q0;  assign bus0.ram_rdata = ram_q0;
    assign bus1.rom_data = rom_q1;  assign bus1.ram_rdata = ram_q1;
    assign bus2.rom_data = rom_q2;

    initial begin
        for (int i = 0; i < 64; i++) begin
            rom0[i] = rom_val(6'(i));
            rom1[i] = rom_val(6'(i));
        end
        for (int i = 0; i < 1024; i++) rom2[i] = 32'(i) * 32'h0001_0003;
        rom2[1023] = 32'hDEADBEEF;
    end

    // Synchronous-read ROM/RAM models.
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 64; i++) begin
                ram0[i] <= '0;
                ram1[i] <= '0;
            end
            rom_q0 <= '0; rom_q1 <= '0; ram_q0 <= '0; ram_q1 <= '0; rom_q2 <= '0;
        end else begin
            if (bus0.rom_en) rom_q0 <= rom0[bus0.rom_addr];
            if (bus0.ram_re) ram_q0 <= ram0[bus0.ram_addr];
            if (bus0.ram_we) ram0[bus0.ram_addr] <= bus0.ram_wdata;
            if (bus1.rom_en) rom_q1 <= rom1[bus1.rom_addr];
            if (bus1.ram_re) ram_q1 <= ram1[bus1.ram_addr];
            if (bus1.ram_we) ram1[bus1.ram_addr] <= bus1.ram_wdata;
            if (bus2.rom_en) rom_q2 <= rom2[bus2.rom_addr];
        end
    end

    // ---------------- reference model state ----------------
    logic [15:0] ram_m [2][64];
    logic [15:0] last_ld [2];

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One transaction on u0/u1: kind 0 = fetch, 1 = load, 2 = store.
    task automatic run_txn(input int k, input int kind, input logic [5:0] a,
                           input logic [15:0] wd, input logic [15:0] exp_d, input int exp_lat);
        int w, lat, en_cnt, err, late_en;
        logic [15:0] got;
        logic [5:0] got_a;
        logic v, en, any_en;
        w = (kind == 0) ? rom_w[k] : ram_w[k];
        lat = 0; en_cnt = 0; err = 0; late_en = 0; got = '0; got_a = '0;
        @(negedge clk);
        if ((o_fv[k] | o_lv[k]) !== 1'b0) err++;
        if (kind == 0) begin
            f_req[k] = 1'b1; f_addr[k] = a;
        end else begin
            l_req[k] = 1'b1; l_we[k] = (kind == 2); l_addr[k] = a; l_wdata[k] = wd;
        end
        #1;
        if (o_stall[k] !== 1'b1) err++;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) begin
                f_addr[k] = 6'($urandom); l_addr[k] = 6'($urandom); l_wdata[k] = 16'($urandom);
            end
            v = (kind == 0) ? o_fv[k] : o_lv[k];
            en = (kind == 0) ? o_rom_en[k] : ((kind == 1) ? o_ram_re[k] : o_ram_we[k]);
            any_en = o_rom_en[k] | o_ram_re[k] | o_ram_we[k];
            if (v) begin
                lat = c;
                got = (kind == 0) ? o_fd[k] : o_ld[k];
                got_a = (kind == 0) ? o_rom_addr[k] : o_ram_addr[k];
                if (any_en) late_en++;
                if (o_stall[k] !== 1'b0) err++;
                break;
            end
            if (en) en_cnt++;
            if (any_en && !en) err++;
            if (o_stall[k] !== 1'b1) err++;
        end
        f_req[k] = 1'b0; l_req[k] = 1'b0;
        check($sformatf("lat k%0d kind%0d a%0h", k, kind, a), 64'(lat), 64'(exp_lat));
        check($sformatf("data k%0d kind%0d a%0h", k, kind, a), 64'(got), 64'(exp_d));
        check($sformatf("addr k%0d kind%0d", k, kind), 64'(got_a), 64'(a));
        check($sformatf("en_cycles k%0d kind%0d", k, kind), 64'(en_cnt),
              64'((kind == 2) ? 1 : w + 1));
        check($sformatf("proto k%0d kind%0d", k, kind), 64'(err), 64'd0);
        check($sformatf("en_in_resp k%0d kind%0d", k, kind), 64'(late_en), 64'd0);
    endtask

    typedef struct {
        int          k;
        int          kind;
        logic [5:0]  addr;
        logic [15:0] wdata;
        logic [15:0] exp_d;
        int          exp_lat;
    } vec_t;
    vec_t vecs [12];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lv_cnt, fv_cnt, lv_at, fv_at, lat;
        logic [15:0] ld, fd, exp_d;
        logic [31:0] d32;
        logic [9:0] a32;
        int k, kind;
        logic [5:0] a;
        logic [15:0] wd;

        reset = 1'b1; mem_clr = 1'b1; f_req2 = 1'b0; f_addr2 = '0;
        for (int i = 0; i < 2; i++) begin
            f_req[i] = 0; l_req[i] = 0; l_we[i] = 0; f_addr[i] = 0; l_addr[i] = 0; l_wdata[i] = 0;
            last_ld[i] = '0;
            for (int j = 0; j < 64; j++) ram_m[i][j] = '0;
        end
        repeat (3) @(negedge clk);
        // Reset state.
        check("rst_state0", 64'(st0), 64'd0);
        check("rst_state1", 64'(st1), 64'd0);
        check("rst_state2", 64'(st2), 64'd0);
        for (int i = 0; i < 2; i++)
            check($sformatf("rst_outs%0d", i),
                  {o_fv[i], o_lv[i], o_stall[i], o_rom_en[i], o_ram_re[i], o_ram_we[i],
                   o_fd[i], o_ld[i], o_rom_addr[i], o_ram_addr[i]}, 64'd0);
        check("rst_outs2", {bus2.fetch_valid, bus2.rom_en, bus2.stall, bus2.rom_addr,
                            bus2.fetch_data}, 64'd0);
        reset = 1'b0; mem_clr = 1'b0;

        // Directed vectors.
        vecs[0]  = '{0, 0, 6'h05, 16'h0000, 16'hA5C3, 2};
        vecs[1]  = '{0, 2, 6'h3F, 16'h1234, 16'h0000, 4};
        vecs[2]  = '{0, 1, 6'h3F, 16'h0000, 16'h1234, 4};
        vecs[3]  = '{0, 0, 6'h0A, 16'h0000, 16'h8A0A, 2};
        vecs[4]  = '{0, 2, 6'h00, 16'hBEEF, 16'h1234, 4};
        vecs[5]  = '{0, 1, 6'h00, 16'h0000, 16'hBEEF, 4};
        vecs[6]  = '{0, 1, 6'h01, 16'h0000, 16'h0000, 4};
        vecs[7]  = '{1, 0, 6'h3F, 16'h0000, 16'hBF3F, 4};
        vecs[8]  = '{1, 2, 6'h20, 16'hCAFE, 16'h0000, 5};
        vecs[9]  = '{1, 1, 6'h20, 16'h0000, 16'hCAFE, 5};
        vecs[10] = '{1, 2, 6'h20, 16'h0001, 16'hCAFE, 5};
        vecs[11] = '{1, 1, 6'h20, 16'h0000, 16'h0001, 5};
        for (int i = 0; i < 12; i++) begin
            run_txn(vecs[i].k, vecs[i].kind, vecs[i].addr, vecs[i].wdata,
                    vecs[i].exp_d, vecs[i].exp_lat);
            if (vecs[i].kind == 2) ram_m[vecs[i].k][vecs[i].addr] = vecs[i].wdata;
            if (vecs[i].kind == 1) last_ld[vecs[i].k] = vecs[i].exp_d;
        end

        // Simultaneous load and fetch: load first, fetch after the RESP/IDLE.
        @(negedge clk);
        f_req[0] = 1'b1; f_addr[0] = 6'h07;
        l_req[0] = 1'b1; l_we[0] = 1'b0; l_addr[0] = 6'h3F;
        lv_cnt = 0; fv_cnt = 0; lv_at = 0; fv_at = 0; ld = '0; fd = '0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (o_lv[0]) begin lv_cnt++; lv_at = c; ld = o_ld[0]; l_req[0] = 1'b0; end
            if (o_fv[0]) begin fv_cnt++; fv_at = c; fd = o_fd[0]; f_req[0] = 1'b0; end
        end
        f_req[0] = 1'b0; l_req[0] = 1'b0;
        check("prio_ls_count", 64'(lv_cnt), 64'd1);
        check("prio_f_count", 64'(fv_cnt), 64'd1);
        check("prio_ls_at", 64'(lv_at), 64'd4);
        check("prio_f_at", 64'(fv_at), 64'd7);
        check("prio_ls_data", 64'(ld), 64'h1234);
        check("prio_f_data", 64'(fd), 64'h8707);
        last_ld[0] = 16'h1234;

        // Reset during the second ACCESS cycle of a RAM_WAIT=3 load on u1.
        @(negedge clk);
        l_req[1] = 1'b1; l_we[1] = 1'b0; l_addr[1] = 6'h20;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1; l_req[1] = 1'b0;
        @(negedge clk);
        check("midrst_state", 64'(st1), 64'd0);
        check("midrst_outs", {o_fv[1], o_lv[1], o_stall[1], o_rom_en[1], o_ram_re[1], o_ram_we[1],
                              o_fd[1], o_ld[1], o_rom_addr[1], o_ram_addr[1]}, 64'd0);
        check("midrst_wdata", 64'(o_wdata[1]), 64'd0);
        reset = 1'b0;
        last_ld[0] = '0; last_ld[1] = '0;
        lv_cnt = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (o_lv[1]) lv_cnt++;
        end
        check("midrst_no_valid", 64'(lv_cnt), 64'd0);
        run_txn(1, 1, 6'h20, 16'h0000, 16'h0001, 5);
        last_ld[1] = 16'h0001;

        // Wide instance: top-of-range fetch.
        @(negedge clk);
        f_req2 = 1'b1; f_addr2 = 10'h3FF;
        lat = 0; d32 = '0; a32 = '0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (bus2.fetch_valid) begin lat = c; d32 = bus2.fetch_data; a32 = bus2.rom_addr; break; end
        end
        f_req2 = 1'b0;
        check("wide_data", 64'(d32), 64'hDEADBEEF);
        check("wide_addr", 64'(a32), 64'h3FF);
        check("wide_lat", 64'(lat), 64'd3);

        // Random traffic against the reference model.
        for (int n = 0; n < 200; n++) begin
            k = $urandom_range(0, 1);
            kind = $urandom_range(0, 2);
            a = 6'($urandom);
            wd = 16'($urandom);
            if (kind == 0) begin
                exp_d = rom_val(a);
            end else if (kind == 1) begin
                exp_d = ram_m[k][a];
                last_ld[k] = exp_d;
            end else begin
                exp_d = last_ld[k];
                ram_m[k][a] = wd;
            end
            run_txn(k, kind, a, wd, exp_d, ((kind == 0) ? rom_w[k] : ram_w[k]) + 2);
        end

        @(negedge clk);
        for (int i = 0; i < 64; i++) begin
            check($sformatf("ram0[%0d]", i), 64'(ram0[i]), 64'(ram_m[0][i]));
            check($sformatf("ram1[%0d]", i), 64'(ram1[i]), 64'(ram_m[1][i]));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
